data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 1024, meaning byte capacity of storage (power of two, at least 8).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to resp_valid (range 1..15).
REQ-003 SHALL have a single clock and a synchronous, active-high reset, named clk and reset as in the rest of the codebase.
REQ-004 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, responder can accept a request.
REQ-008 SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port xfer_size, input, 4, bytes to transfer (4'd8 doubleword, 4'd1 byte), same encoding as the datapath's xsize_loc_in.
REQ-010 SHALL have port address, input, 64, byte address.
REQ-011 SHALL have port wr_data, input, 64, store data (byte store uses [7:0]).
REQ-012 SHALL have port resp_valid, output, 1, response present.
REQ-013 SHALL have port resp_ready, input, 1, initiator accepts the response.
REQ-014 SHALL have port Dout, output, 64, load data.
REQ-015 SHALL have port resp_err, output, 1, the request was illegal.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; there is no acceptance in WAIT or RESP.
REQ-018 SHALL accept a request on a clk edge with req_valid&&req_ready, latch req_write/xfer_size/address/wr_data, and go IDLE->WAIT.
REQ-019 SHALL count in WAIT so that resp_valid rises exactly LATENCY cycles after the accept edge; LATENCY=1 means WAIT lasts zero visible cycles (IDLE->RESP directly).
REQ-020 SHALL hold resp_valid, Dout and resp_err stable in RESP until resp_valid&&resp_ready, then return to IDLE on that edge.
REQ-021 SHALL allow resp_ready=1 at RESP entry to complete the response in one cycle, with req_ready=1 on the next cycle.
REQ-022 SHALL flag an illegal request for any of: address >= DEPTH_BYTES; xfer_size==8 with address[2:0]!=0; xfer_size not in {1,8}.
REQ-023 SHALL NOT modify storage on an illegal request, and SHALL respond with resp_err=1 and Dout=0.
REQ-024 SHALL commit a legal store on the edge entering RESP, store little-endian (wr_data[7:0] at address), and respond with Dout=0 and resp_err=0.
REQ-025 SHALL return a legal doubleword load little-endian in Dout[63:0].
REQ-026 SHALL return a legal byte load in Dout[7:0] with Dout[63:8]=0.
REQ-027 SHALL make a load after a completed store to the same bytes return the new data (no stale read).
REQ-028 SHALL drive Dout=0 and resp_err=0 whenever resp_valid=0.
REQ-029 SHALL ignore wr_data changes after acceptance.

Reset
REQ-030 SHALL, on reset=1 at a clk edge, force state=IDLE, wait counter=0, resp_valid=0, resp_err=0, Dout=0, and req_ready=1 the following cycle.
REQ-031 SHALL abort a request if reset occurs in WAIT: no store is committed and no response is given.
REQ-032 SHALL drop a response held in RESP on reset; storage keeps the already-committed store.
REQ-033 SHALL NOT clear storage contents on reset.

Structure
REQ-034 SHALL define in shared package data_mem_pkg: state enum (IDLE, WAIT, RESP), constants SIZE_DWORD=4'd8 and SIZE_BYTE=4'd1, shared with the datapath's xsize mux.
REQ-035 SHALL place storage in one sub-module, data_mem_array: byte-addressable, 8 byte-lane write enables, 64-bit read port; FSM, counter and legality check stay in data_mem_responder.

Verification
REQ-036 SHALL verify: after reset, store dword 0x1122334455667788 at 0x10 (LATENCY=2) -> resp_valid exactly 2 cycles after accept, resp_err=0; dword load at 0x10 -> Dout=0x1122334455667788.
REQ-037 SHALL verify: byte store 0xAB at 0x13, then dword load at 0x10 -> Dout=0x11223344AB667788; byte load at 0x13 -> Dout=0x00000000000000AB.
REQ-038 SHALL verify: dword load at 0x0C -> resp_err=1, Dout=0; store at address 1024 -> resp_err=1 and memory unchanged; xfer_size=4'd2 -> resp_err=1.
REQ-039 SHALL verify: hold resp_ready=0 for 5 cycles in RESP -> resp_valid/Dout stable and req_ready=0 throughout; complete the response -> req_ready=1 next cycle.
REQ-040 SHALL verify: accept a store of 0xFF..FF at 0x20, assert reset during WAIT -> no response; load 0x20 -> previous contents returned.
REQ-041 SHALL verify: with LATENCY=1 and resp_ready tied high, back-to-back requests -> one accept every 2 cycles, each response 1 cycle after its accept.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory responder and the datapath xsize mux.
// Holds the FSM state encoding, transfer-size codes and the request legality check.
package data_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [3:0] SIZE_DWORD = 4'd8;
   localparam logic [3:0] SIZE_BYTE  = 4'd1;

   // A request is illegal when out of range, a misaligned doubleword, or an unknown size.
   function automatic logic req_illegal(input logic [63:0] addr,
                                        input logic [3:0]  size,
                                        input logic [63:0] depth);
      logic bad_range;
      logic bad_align;
      logic bad_size;
      bad_range = (addr >= depth);
      bad_align = (size == SIZE_DWORD) && (addr[2:0] != 3'd0);
      bad_size  = (size != SIZE_DWORD) && (size != SIZE_BYTE);
      return bad_range || bad_align || bad_size;
   endfunction

endpackage

// File: rtl/data_mem_array.sv
// Byte-addressable storage built as eight byte-lane RAMs sharing one word address.
// Each lane has its own write enable; reads are registered and return the full 64-bit word.
module data_mem_array
#(
   parameter int WORDS  = 128,
   parameter int WORD_W = 7
)
(
   input  logic              clk,
   input  logic              wr_en,
   input  logic [7:0]        wr_be,
   input  logic [WORD_W-1:0] addr,
   input  logic [63:0]       wr_data,
   output logic [63:0]       rd_data
);

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         logic [7:0] lane_mem [WORDS];
         logic [7:0] rd_lane_reg;

         always_ff @(posedge clk) begin
            if (wr_en && wr_be[gi]) begin
               lane_mem[addr] <= wr_data[8*gi +: 8];
            end
            rd_lane_reg <= lane_mem[addr];
         end

         assign rd_data[8*gi +: 8] = rd_lane_reg;
      end
   endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// Request/response front end for the data memory: accepts one request at a time,
// waits a fixed latency, commits stores and returns load data or an error.
module data_mem_responder
   import data_mem_pkg::*;
#(
   parameter int DEPTH_BYTES = 1024,
   parameter int LATENCY     = 2
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [3:0]  xfer_size,
   input  logic [63:0] address,
   input  logic [63:0] wr_data,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] Dout,
   output logic        resp_err
);

   localparam int          ADDR_W      = $clog2(DEPTH_BYTES);
   localparam int          WORD_W      = (ADDR_W > 3) ? ADDR_W - 3 : 1;
   localparam int          WORDS       = DEPTH_BYTES / 8;
   localparam int          WAIT_LOAD   = (LATENCY > 1) ? LATENCY - 2 : 0;
   localparam logic [63:0] DEPTH_LIMIT = 64'(DEPTH_BYTES);

   state_e      state_reg;
   state_e      state_next;
   logic [3:0]  wait_cnt_reg;
   logic [3:0]  wait_cnt_next;
   logic        write_reg;
   logic [3:0]  size_reg;
   logic [63:0] addr_reg;
   logic [63:0] wr_data_reg;

   logic        accept;
   logic        enter_resp;
   logic        cur_write;
   logic [3:0]  cur_size;
   logic [63:0] cur_addr;
   logic [63:0] cur_wr_data;

   logic              mem_wr_en;
   logic [7:0]        mem_wr_be;
   logic [63:0]       mem_wr_data;
   logic [63:0]       mem_rd_data;
   logic [WORD_W-1:0] mem_addr;

   logic        resp_bad;
   logic [63:0] load_data;

   assign req_ready = (state_reg == IDLE);
   assign accept    = req_valid && req_ready;

   // In IDLE the live inputs are the request in flight (LATENCY=1 enters RESP on the accept edge).
   always_comb begin
      cur_write   = write_reg;
      cur_size    = size_reg;
      cur_addr    = addr_reg;
      cur_wr_data = wr_data_reg;
      if (state_reg == IDLE) begin
         cur_write   = req_write;
         cur_size    = xfer_size;
         cur_addr    = address;
         cur_wr_data = wr_data;
      end
   end

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_next = RESP;
               end else begin
                  state_next    = WAIT;
                  wait_cnt_next = 4'(WAIT_LOAD);
               end
            end
         end
         WAIT: begin
            if (wait_cnt_reg == 4'd0) begin
               state_next = RESP;
            end else begin
               wait_cnt_next = wait_cnt_reg - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign enter_resp = (state_reg != RESP) && (state_next == RESP);

   // Store commits on the edge entering RESP; a reset on that same edge aborts it.
   assign mem_wr_en   = enter_resp && !reset && cur_write &&
                        !req_illegal(cur_addr, cur_size, DEPTH_LIMIT);
   assign mem_wr_be   = (cur_size == SIZE_DWORD) ? 8'hFF : (8'h01 << cur_addr[2:0]);
   assign mem_wr_data = (cur_size == SIZE_DWORD) ? cur_wr_data : {8{cur_wr_data[7:0]}};
   assign mem_addr    = cur_addr[WORD_W+2:3];

   data_mem_array #(
      .WORDS  (WORDS),
      .WORD_W (WORD_W)
   ) u_array (
      .clk     (clk),
      .wr_en   (mem_wr_en),
      .wr_be   (mem_wr_be),
      .addr    (mem_addr),
      .wr_data (mem_wr_data),
      .rd_data (mem_rd_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         wait_cnt_reg <= 4'd0;
         write_reg    <= 1'b0;
         size_reg     <= 4'd0;
         addr_reg     <= 64'd0;
         wr_data_reg  <= 64'd0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         if (accept) begin
            write_reg   <= req_write;
            size_reg    <= xfer_size;
            addr_reg    <= address;
            wr_data_reg <= wr_data;
         end
      end
   end

   // The read word stays stable through RESP because nothing writes while a response is held.
   assign resp_valid = (state_reg == RESP);
   assign resp_bad   = req_illegal(addr_reg, size_reg, DEPTH_LIMIT);
   assign resp_err   = resp_valid && resp_bad;

   always_comb begin
      load_data = {56'd0, mem_rd_data[{addr_reg[2:0], 3'b000} +: 8]};
      if (size_reg == SIZE_DWORD) begin
         load_data = mem_rd_data;
      end
   end

   assign Dout = (resp_valid && !resp_bad && !write_reg) ? load_data : 64'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LATENCY=2 instance for function and reset cases,
// LATENCY=1 instance for back-to-back throughput.
module tb_data_mem_responder;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [3:0]  xfer_size;
   logic [63:0] address;
   logic [63:0] wr_data;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] Dout;
   logic        resp_err;

   logic        b_req_valid;
   logic        b_req_ready;
   logic        b_req_write;
   logic [3:0]  b_xfer_size;
   logic [63:0] b_address;
   logic [63:0] b_wr_data;
   logic        b_resp_valid;
   logic        b_resp_ready;
   logic [63:0] b_Dout;
   logic        b_resp_err;

   int checks;
   int failures;

   data_mem_responder #(.DEPTH_BYTES(1024), .LATENCY(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .xfer_size  (xfer_size),
      .address    (address),
      .wr_data    (wr_data),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .Dout       (Dout),
      .resp_err   (resp_err)
   );

   data_mem_responder #(.DEPTH_BYTES(1024), .LATENCY(1)) dut1 (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (b_req_valid),
      .req_ready  (b_req_ready),
      .req_write  (b_req_write),
      .xfer_size  (b_xfer_size),
      .address    (b_address),
      .wr_data    (b_wr_data),
      .resp_valid (b_resp_valid),
      .resp_ready (b_resp_ready),
      .Dout       (b_Dout),
      .resp_err   (b_resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One complete transaction on the LATENCY=2 instance; caller is 1ns after an edge in IDLE.
   task automatic txn(input logic w, input logic [3:0] sz, input logic [63:0] a,
                      input logic [63:0] d, output logic [63:0] dout_o,
                      output logic err_o, output int lat_o);
      req_write = w;
      xfer_size = sz;
      address   = a;
      wr_data   = d;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_write = ~w;
      xfer_size = 4'hF;
      address   = ~a;
      wr_data   = ~d;
      lat_o = 1;
      while (!resp_valid && lat_o < 20) begin
         @(posedge clk); #1;
         lat_o++;
      end
      dout_o = Dout;
      err_o  = resp_err;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      $display("txn write=%0d size=%0d addr=0x%h data=0x%h -> dout=0x%h err=%0d lat=%0d",
               w, sz, a, d, dout_o, err_o, lat_o);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_resp_valid: got %b want 0", resp_valid);
      end
      checks++;
      if (resp_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_resp_err: got %b want 0", resp_err);
      end
      checks++;
      if (Dout !== 64'd0) begin
         failures++;
         $display("FAIL reset_dout: got 0x%h want 0", Dout);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_req_ready: got %b want 1", req_ready);
      end
      checks++;
      if (b_req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_req_ready_l1: got %b want 1", b_req_ready);
      end
   endtask

   task automatic test_dword();
      logic [63:0] d;
      logic        e;
      int          l;
      txn(1'b1, 4'd8, 64'h10, 64'h1122334455667788, d, e, l);
      checks++;
      if (l !== 2) begin
         failures++;
         $display("FAIL dword_store_latency: got %0d want 2", l);
      end
      checks++;
      if (e !== 1'b0 || d !== 64'd0) begin
         failures++;
         $display("FAIL dword_store_resp: got err=%b dout=0x%h want err=0 dout=0", e, d);
      end
      txn(1'b0, 4'd8, 64'h10, 64'h0, d, e, l);
      checks++;
      if (d !== 64'h1122334455667788 || e !== 1'b0) begin
         failures++;
         $display("FAIL dword_load: got 0x%h err=%b want 0x1122334455667788 err=0", d, e);
      end
      checks++;
      if (l !== 2) begin
         failures++;
         $display("FAIL dword_load_latency: got %0d want 2", l);
      end
   endtask

   task automatic test_byte();
      logic [63:0] d;
      logic        e;
      int          l;
      txn(1'b1, 4'd1, 64'h13, 64'hDEADBEEF000000AB, d, e, l);
      checks++;
      if (e !== 1'b0 || d !== 64'd0) begin
         failures++;
         $display("FAIL byte_store_resp: got err=%b dout=0x%h want err=0 dout=0", e, d);
      end
      txn(1'b0, 4'd8, 64'h10, 64'h0, d, e, l);
      checks++;
      if (d !== 64'h11223344AB667788) begin
         failures++;
         $display("FAIL byte_merge_dword: got 0x%h want 0x11223344ab667788", d);
      end
      txn(1'b0, 4'd1, 64'h13, 64'h0, d, e, l);
      checks++;
      if (d !== 64'h00000000000000AB || e !== 1'b0) begin
         failures++;
         $display("FAIL byte_load_13: got 0x%h err=%b want 0xab err=0", d, e);
      end
      txn(1'b0, 4'd1, 64'h10, 64'h0, d, e, l);
      checks++;
      if (d !== 64'h0000000000000088) begin
         failures++;
         $display("FAIL byte_load_10: got 0x%h want 0x88", d);
      end
   endtask

   task automatic test_illegal();
      logic [63:0] d;
      logic        e;
      int          l;
      txn(1'b1, 4'd8, 64'h0, 64'hCAFEF00D12345678, d, e, l);
      txn(1'b0, 4'd8, 64'h0C, 64'h0, d, e, l);
      checks++;
      if (e !== 1'b1 || d !== 64'd0) begin
         failures++;
         $display("FAIL misaligned_load: got err=%b dout=0x%h want err=1 dout=0", e, d);
      end
      txn(1'b1, 4'd8, 64'd1024, 64'hFFFFFFFFFFFFFFFF, d, e, l);
      checks++;
      if (e !== 1'b1 || d !== 64'd0) begin
         failures++;
         $display("FAIL range_store: got err=%b dout=0x%h want err=1 dout=0", e, d);
      end
      txn(1'b0, 4'd8, 64'h0, 64'h0, d, e, l);
      checks++;
      if (d !== 64'hCAFEF00D12345678) begin
         failures++;
         $display("FAIL range_store_unchanged: got 0x%h want 0xcafef00d12345678", d);
      end
      txn(1'b0, 4'd2, 64'h10, 64'h0, d, e, l);
      checks++;
      if (e !== 1'b1 || d !== 64'd0) begin
         failures++;
         $display("FAIL size2_load: got err=%b dout=0x%h want err=1 dout=0", e, d);
      end
      txn(1'b1, 4'd2, 64'h10, 64'h0, d, e, l);
      txn(1'b0, 4'd8, 64'h10, 64'h0, d, e, l);
      checks++;
      if (d !== 64'h11223344AB667788) begin
         failures++;
         $display("FAIL size2_store_unchanged: got 0x%h want 0x11223344ab667788", d);
      end
      txn(1'b1, 4'd1, 64'd1023, 64'h5A, d, e, l);
      txn(1'b0, 4'd1, 64'd1023, 64'h0, d, e, l);
      checks++;
      if (d !== 64'h5A || e !== 1'b0) begin
         failures++;
         $display("FAIL last_byte: got 0x%h err=%b want 0x5a err=0", d, e);
      end
   endtask

   task automatic test_backpressure();
      req_write = 1'b0;
      xfer_size = 4'd8;
      address   = 64'h10;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b0 || Dout !== 64'd0) begin
         failures++;
         $display("FAIL bp_wait: got valid=%b ready=%b dout=0x%h want 0 0 0",
                  resp_valid, req_ready, Dout);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (resp_valid !== 1'b1 || req_ready !== 1'b0 || Dout !== 64'h11223344AB667788) begin
            failures++;
            $display("FAIL bp_hold_%0d: got valid=%b ready=%b dout=0x%h want 1 0 0x11223344ab667788",
                     i, resp_valid, req_ready, Dout);
         end
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      $display("txn backpressure load addr=0x10 held 5 cycles");
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || Dout !== 64'd0) begin
         failures++;
         $display("FAIL bp_release: got ready=%b valid=%b dout=0x%h want 1 0 0",
                  req_ready, resp_valid, Dout);
      end
   endtask

   task automatic test_reset_abort();
      logic [63:0] d;
      logic        e;
      int          l;
      int          seen;
      txn(1'b1, 4'd8, 64'h20, 64'h0123456789ABCDEF, d, e, l);
      req_write = 1'b1;
      xfer_size = 4'd8;
      address   = 64'h20;
      wr_data   = 64'hFFFFFFFFFFFFFFFF;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (resp_valid) seen++;
         @(posedge clk); #1;
      end
      $display("txn aborted store addr=0x20 data=0xffffffffffffffff by reset in WAIT");
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL abort_no_resp: got %0d response cycles want 0", seen);
      end
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL abort_req_ready: got %b want 1", req_ready);
      end
      txn(1'b0, 4'd8, 64'h20, 64'h0, d, e, l);
      checks++;
      if (d !== 64'h0123456789ABCDEF) begin
         failures++;
         $display("FAIL abort_no_commit: got 0x%h want 0x0123456789abcdef", d);
      end
      req_write = 1'b1;
      xfer_size = 4'd8;
      address   = 64'h28;
      wr_data   = 64'h55AA55AA00FF00FF;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1) begin
         failures++;
         $display("FAIL drop_resp_entry: got valid=%b want 1", resp_valid);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      $display("txn store addr=0x28 dropped in RESP by reset");
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL drop_resp: got valid=%b ready=%b want 0 1", resp_valid, req_ready);
      end
      txn(1'b0, 4'd8, 64'h28, 64'h0, d, e, l);
      checks++;
      if (d !== 64'h55AA55AA00FF00FF) begin
         failures++;
         $display("FAIL drop_keeps_store: got 0x%h want 0x55aa55aa00ff00ff", d);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] vals [4];
      logic [63:0] exp_d;
      int          nacc;
      int          last;
      logic        took;
      vals[0] = 64'hA5A5A5A5A5A5A5A5;
      vals[1] = 64'h0102030405060708;
      vals[2] = 64'hFEDCBA9876543210;
      vals[3] = 64'h00000000DEADBEEF;
      nacc = 0;
      last = 0;
      b_resp_ready = 1'b1;
      b_req_write  = 1'b1;
      b_xfer_size  = 4'd8;
      b_address    = 64'h0;
      b_wr_data    = vals[0];
      b_req_valid  = 1'b1;
      for (int c = 1; c <= 40 && nacc < 8; c++) begin
         took = b_req_ready && b_req_valid;
         @(posedge clk); #1;
         if (took) begin
            exp_d = (nacc < 4) ? 64'd0 : vals[nacc - 4];
            $display("txn b2b idx=%0d write=%0d addr=0x%h cycle=%0d -> valid=%b dout=0x%h",
                     nacc, b_req_write, b_address, c, b_resp_valid, b_Dout);
            checks++;
            if (b_resp_valid !== 1'b1 || b_Dout !== exp_d || b_resp_err !== 1'b0) begin
               failures++;
               $display("FAIL b2b_resp_%0d: got valid=%b dout=0x%h err=%b want 1 0x%h 0",
                        nacc, b_resp_valid, b_Dout, b_resp_err, exp_d);
            end
            checks++;
            if (b_req_ready !== 1'b0) begin
               failures++;
               $display("FAIL b2b_ready_%0d: got %b want 0", nacc, b_req_ready);
            end
            if (nacc > 0) begin
               checks++;
               if (c - last !== 2) begin
                  failures++;
                  $display("FAIL b2b_interval_%0d: got %0d want 2", nacc, c - last);
               end
            end
            last = c;
            nacc++;
            if (nacc < 8) begin
               b_req_write = (nacc < 4);
               b_address   = 64'((nacc % 4) * 8);
               b_wr_data   = (nacc < 4) ? vals[nacc] : 64'hFFFFFFFFFFFFFFFF;
            end else begin
               b_req_valid = 1'b0;
            end
         end
      end
      b_req_valid = 1'b0;
      checks++;
      if (nacc !== 8) begin
         failures++;
         $display("FAIL b2b_count: got %0d accepts want 8", nacc);
      end
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      reset        = 1'b1;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      xfer_size    = 4'd0;
      address      = 64'd0;
      wr_data      = 64'd0;
      resp_ready   = 1'b0;
      b_req_valid  = 1'b0;
      b_req_write  = 1'b0;
      b_xfer_size  = 4'd0;
      b_address    = 64'd0;
      b_wr_data    = 64'd0;
      b_resp_ready = 1'b0;
      test_reset();
      test_dword();
      test_byte();
      test_illegal();
      test_backpressure();
      test_reset_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
